// File: rtl/register_bank.sv
// MIPS general-purpose register file: two bypassed combinational read ports, one WB write port,
// and a handshaked engine that streams every register to the debug unit.
module register_bank #(
    parameter int unsigned REGS      = 32,
    parameter int unsigned BUS_SIZE  = 32,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [ADDR_BITS-1:0] addr_wr,
    input  logic [BUS_SIZE-1:0]  data_wr,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [ADDR_BITS-1:0] addr_b,
    output logic [BUS_SIZE-1:0]  bus_a,
    output logic [BUS_SIZE-1:0]  bus_b,
    input  logic                 dump_start,
    input  logic                 dump_ready,
    output logic                 dump_valid,
    output logic [ADDR_BITS-1:0] dump_addr,
    output logic [BUS_SIZE-1:0]  dump_data,
    output logic                 dump_busy,
    output logic                 dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    logic [BUS_SIZE-1:0]  regs [REGS];
    state_t               state, state_next;
    logic [ADDR_BITS-1:0] idx, idx_next;

    // NOTE: the whole array is cleared on reset because software may dump or read any register
    // before writing it; this forces flops rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && addr_wr != '0) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            regs[addr_wr] <= data_wr;
        end
    end

    // r0 is hard-wired to zero, so the bypass must never forward a write aimed at it.
    assign bus_a = (addr_a == '0) ? '0 :
                   (write_enable && addr_wr == addr_a) ? data_wr : regs[addr_a];
    assign bus_b = (addr_b == '0) ? '0 :
                   (write_enable && addr_wr == addr_b) ? data_wr : regs[addr_b];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_next = state;
        idx_next   = idx;
        dump_valid = 1'b0;
        dump_busy  = 1'b0;
        dump_done  = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;

        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_addr  = idx;
                dump_data  = regs[idx];
                if (dump_ready) begin
                    if (idx == ADDR_BITS'(REGS - 1)) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_busy  = 1'b1;
                dump_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, r0 rules, bypass, full dump,
// dump under backpressure with a concurrent write, and reset in the middle of a dump.
module tb_register_bank;

    localparam int REGS      = 32;
    localparam int BUS_SIZE  = 32;
    localparam int ADDR_BITS = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 write_enable;
    logic [ADDR_BITS-1:0] addr_wr;
    logic [BUS_SIZE-1:0]  data_wr;
    logic [ADDR_BITS-1:0] addr_a;
    logic [ADDR_BITS-1:0] addr_b;
    logic [BUS_SIZE-1:0]  bus_a;
    logic [BUS_SIZE-1:0]  bus_b;
    logic                 dump_start;
    logic                 dump_ready;
    logic                 dump_valid;
    logic [ADDR_BITS-1:0] dump_addr;
    logic [BUS_SIZE-1:0]  dump_data;
    logic                 dump_busy;
    logic                 dump_done;

    int compared   = 0;
    int mismatched = 0;

    logic [BUS_SIZE-1:0] expect_reg [REGS];
    int                  e;
    int                  cyc;

    register_bank #(
        .REGS     (REGS),
        .BUS_SIZE (BUS_SIZE),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write_enable(write_enable),
        .addr_wr     (addr_wr),
        .data_wr     (data_wr),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .bus_a       (bus_a),
        .bus_b       (bus_b),
        .dump_start  (dump_start),
        .dump_ready  (dump_ready),
        .dump_valid  (dump_valid),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_busy   (dump_busy),
        .dump_done   (dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later still.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, " valid"}, 32'(dump_valid), 32'd0);
        check({tag, " busy"},  32'(dump_busy),  32'd0);
        check({tag, " done"},  32'(dump_done),  32'd0);
        check({tag, " addr"},  32'(dump_addr),  32'd0);
        check({tag, " data"},  dump_data,       32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        write_enable = 1'b0;
        addr_wr      = '0;
        data_wr      = '0;
        addr_a       = '0;
        addr_b       = '0;
        dump_start   = 1'b0;
        dump_ready   = 1'b0;

        // 1: reset clears everything
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check_dump_idle("reset dump");
        for (int i = 0; i < REGS; i++) begin
            addr_a = ADDR_BITS'(i);
            addr_b = ADDR_BITS'(REGS - 1 - i);
            #1;
            check($sformatf("reset bus_a r%0d", i), bus_a, 32'd0);
            check($sformatf("reset bus_b r%0d", REGS - 1 - i), bus_b, 32'd0);
        end

        // 2: ordinary write, write to r0 is dropped
        next_cycle();
        write_enable = 1'b1;
        addr_wr      = 5'd5;
        data_wr      = 32'hDEADBEEF;
        next_cycle();
        addr_wr      = 5'd0;
        data_wr      = 32'h12345678;
        next_cycle();
        write_enable = 1'b0;
        addr_a       = 5'd5;
        addr_b       = 5'd0;
        #1;
        check("write r5", bus_a, 32'hDEADBEEF);
        check("write r0 ignored", bus_b, 32'd0);

        // 3: write-through bypass, and no bypass for r0
        next_cycle();
        write_enable = 1'b1;
        addr_wr      = 5'd7;
        data_wr      = 32'hA5A5A5A5;
        addr_a       = 5'd7;
        addr_b       = 5'd7;
        #1;
        check("bypass bus_a", bus_a, 32'hA5A5A5A5);
        check("bypass bus_b", bus_b, 32'hA5A5A5A5);
        next_cycle();
        write_enable = 1'b0;
        #1;
        check("r7 committed", bus_a, 32'hA5A5A5A5);
        next_cycle();
        write_enable = 1'b1;
        addr_wr      = 5'd0;
        data_wr      = 32'hA5A5A5A5;
        addr_a       = 5'd0;
        addr_b       = 5'd0;
        #1;
        check("bypass r0 bus_a", bus_a, 32'd0);
        check("bypass r0 bus_b", bus_b, 32'd0);

        // 4: preload rN = 3N, then a full dump with ready held high
        for (int n = 1; n < REGS; n++) begin
            next_cycle();
            write_enable = 1'b1;
            addr_wr      = ADDR_BITS'(n);
            data_wr      = 32'(3 * n);
        end
        for (int n = 0; n < REGS; n++) expect_reg[n] = 32'(3 * n);
        next_cycle();
        write_enable = 1'b0;
        dump_ready   = 1'b1;
        dump_start   = 1'b1;
        #1;
        check("start cycle busy", 32'(dump_busy), 32'd0);
        next_cycle();
        dump_start = 1'b0;
        for (int k = 0; k < REGS; k++) begin
            dump_start = (k == 5);
            #1;
            check($sformatf("full valid k%0d", k), 32'(dump_valid), 32'd1);
            check($sformatf("full addr k%0d", k),  32'(dump_addr),  32'(k));
            check($sformatf("full data k%0d", k),  dump_data,       expect_reg[k]);
            check($sformatf("full done k%0d", k),  32'(dump_done),  32'd0);
            next_cycle();
        end
        dump_start = 1'b0;
        #1;
        // 34th cycle counting the start cycle as the first
        check("full done pulse", 32'(dump_done),  32'd1);
        check("full done busy",  32'(dump_busy),  32'd1);
        check("full done valid", 32'(dump_valid), 32'd0);
        next_cycle();
        #1;
        check_dump_idle("after full dump");

        // 5: backpressure 1,0,0 and a write to r20 before it is sent
        next_cycle();
        dump_start = 1'b1;
        dump_ready = 1'b0;
        next_cycle();
        dump_start = 1'b0;
        e = 0;
        for (cyc = 0; cyc < 200 && e < REGS; cyc++) begin
            dump_ready   = (cyc % 3 == 0);
            write_enable = (e == 3 && cyc % 3 == 1);
            addr_wr      = 5'd20;
            data_wr      = 32'hFFFF0000;
            #1;
            check($sformatf("bp valid c%0d", cyc), 32'(dump_valid), 32'd1);
            check($sformatf("bp addr c%0d", cyc),  32'(dump_addr),  32'(e));
            check($sformatf("bp data c%0d", cyc),  dump_data,       expect_reg[e]);
            if (write_enable) expect_reg[20] = 32'hFFFF0000;
            if (dump_ready) e++;
            next_cycle();
        end
        write_enable = 1'b0;
        dump_ready   = 1'b0;
        #1;
        check("bp all words sent", 32'(e), 32'(REGS));
        check("bp done pulse", 32'(dump_done), 32'd1);
        next_cycle();
        #1;
        check_dump_idle("after bp dump");

        // 6: reset aborts a dump at idx 10, then a fresh dump starts at 0
        dump_ready = 1'b1;
        dump_start = 1'b1;
        next_cycle();
        dump_start = 1'b0;
        for (int k = 0; k < 10; k++) next_cycle();
        #1;
        check("abort at idx10", 32'(dump_addr), 32'd10);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check_dump_idle("after abort");
        for (int i = 1; i < REGS; i += 6) begin
            addr_a = ADDR_BITS'(i);
            addr_b = ADDR_BITS'(i + 1);
            #1;
            check($sformatf("abort clear bus_a r%0d", i), bus_a, 32'd0);
            check($sformatf("abort clear bus_b r%0d", i + 1), bus_b, 32'd0);
        end
        next_cycle();
        #1;
        check("no done after abort", 32'(dump_done), 32'd0);
        dump_start = 1'b1;
        next_cycle();
        dump_start = 1'b0;
        #1;
        check("restart valid", 32'(dump_valid), 32'd1);
        check("restart addr",  32'(dump_addr),  32'd0);
        check("restart data",  dump_data,       32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
